// File: rtl/pipe_ctrl_n_if.sv
// Stall/flush/redirect bundle between the pipeline controller (master) and the core it steers (slave).
interface pipe_ctrl_n_if #(
    parameter int STAGES     = 6,
    parameter int ADDR_WIDTH = 32
);
    logic [STAGES-1:0]     stallreq_i;
    logic                  jump_enable_i;
    logic [ADDR_WIDTH-1:0] jump_addr_i;
    logic                  trap_i;
    logic [ADDR_WIDTH-1:0] trap_vec_i;
    logic                  mem_req_i;
    logic                  mem_ack_i;
    logic [STAGES-1:0]     stall_o;
    logic [STAGES-1:0]     flush_o;
    logic [ADDR_WIDTH-1:0] new_pc_o;
    logic                  new_pc_valid_o;
    logic                  timeout_o;
    logic [1:0]            state_o;

    modport master (
        input  stallreq_i, jump_enable_i, jump_addr_i, trap_i, trap_vec_i, mem_req_i, mem_ack_i,
        output stall_o, flush_o, new_pc_o, new_pc_valid_o, timeout_o, state_o
    );

    modport slave (
        output stallreq_i, jump_enable_i, jump_addr_i, trap_i, trap_vec_i, mem_req_i, mem_ack_i,
        input  stall_o, flush_o, new_pc_o, new_pc_valid_o, timeout_o, state_o
    );
endinterface

// File: rtl/pipe_ctrl_n.sv
// Per-stage stall/flush generation plus registered redirect sequencing for an N-stage in-order core.
// Latency: stall/flush combinational; redirect PC valid one cycle after a jump, two after a trap/timeout.
// Backpressure: a stall at stage k holds stages k..0 and bubbles k+1; memory waits time out after MAX_WAIT.
module pipe_ctrl_n #(
    parameter int                    STAGES      = 6,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    JUMP_STAGE  = 3,
    parameter int                    MEM_STAGE   = 4,
    parameter int                    MAX_WAIT    = 15,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [ADDR_WIDTH-1:0] TIMEOUT_VEC = 'h40
) (
    input logic          clk_i,
    input logic          rst_i,
    pipe_ctrl_n_if.master bus
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]     MAX_W       = CW'(MAX_WAIT);
    localparam logic [STAGES-1:0] MEM_STALL   = STAGES'((64'd1 << (MEM_STAGE + 1)) - 64'd1);
    localparam logic [STAGES-1:0] MEM_FLUSH   = STAGES'(64'd1 << (MEM_STAGE + 1));
    localparam logic [STAGES-1:0] JUMP_FLUSH  = STAGES'((64'd1 << (JUMP_STAGE + 1)) - 64'd2);
    localparam logic [STAGES-1:0] FULL_FLUSH  = ~STAGES'(1);
    localparam logic [STAGES-1:0] REDIR_FLUSH = STAGES'(2);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         wait_q, wait_d;
    logic [ADDR_WIDTH-1:0] tgt_q, tgt_d, pc_q;
    logic                  valid_q, timeout_q, timeout_d;
    logic [STAGES-1:0]     stall_d, flush_d, req_stall, req_flush;

    // req_stall[i] is set when any stage at or beyond i asks to stall; the bubble sits just above the highest.
    always_comb begin
        logic any;
        any       = 1'b0;
        req_stall = '0;
        req_flush = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            any          = any | bus.stallreq_i[i];
            req_stall[i] = any;
        end
        for (int i = 1; i < STAGES; i++) begin
            req_flush[i] = req_stall[i-1] & ~req_stall[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        tgt_d     = tgt_q;
        timeout_d = timeout_q;
        stall_d   = '0;
        flush_d   = '0;
        case (state_q)
            RUN: begin
                if (bus.trap_i) begin
                    flush_d = FULL_FLUSH;
                    tgt_d   = bus.trap_vec_i;
                    state_d = DRAIN;
                end else if (bus.mem_req_i && !bus.mem_ack_i) begin
                    stall_d = MEM_STALL;
                    flush_d = MEM_FLUSH;
                    wait_d  = CW'(1);
                    state_d = MEM_WAIT;
                end else if (bus.jump_enable_i && !req_stall[JUMP_STAGE]) begin
                    flush_d = JUMP_FLUSH;
                    tgt_d   = bus.jump_addr_i;
                    state_d = REDIRECT;
                end else begin
                    // A jump blocked here is simply dropped; the resolving stage presents it again.
                    stall_d = req_stall;
                    flush_d = req_flush;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ack_i) begin
                    wait_d  = '0;
                    state_d = RUN;
                end else if (wait_q < MAX_W) begin
                    stall_d = MEM_STALL;
                    flush_d = MEM_FLUSH;
                    wait_d  = wait_q + CW'(1);
                end else begin
                    flush_d   = FULL_FLUSH;
                    timeout_d = 1'b1;
                    tgt_d     = TIMEOUT_VEC;
                    wait_d    = '0;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                flush_d = FULL_FLUSH;
                state_d = REDIRECT;
            end
            REDIRECT: begin
                flush_d = REDIR_FLUSH;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= RUN;
            wait_q    <= '0;
            tgt_q     <= RESET_PC;
            pc_q      <= RESET_PC;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            tgt_q     <= tgt_d;
            timeout_q <= timeout_d;
            valid_q   <= (state_d == REDIRECT);
            // new_pc_o only moves on entry to REDIRECT so it holds steady through DRAIN.
            if (state_d == REDIRECT) begin
                pc_q <= tgt_d;
            end
        end
    end

    assign bus.stall_o        = rst_i ? stall_d : '0;
    assign bus.flush_o        = rst_i ? flush_d : '0;
    assign bus.new_pc_o       = pc_q;
    assign bus.new_pc_valid_o = valid_q;
    assign bus.timeout_o      = timeout_q;
    assign bus.state_o        = state_q;
endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Directed literal checks plus randomized stimulus compared every cycle against a behavioural model.
module tb_pipe_ctrl_n;
    localparam int S  = 6;
    localparam int JS = 3;
    localparam int MS = 4;
    localparam int MW = 4;
    localparam logic [31:0] TO_VEC = 32'h40;

    logic clk;
    logic rst_i;
    int   errors = 0;
    int   checks = 0;

    pipe_ctrl_n_if #(.STAGES(S), .ADDR_WIDTH(32)) bus ();

    pipe_ctrl_n #(
        .STAGES(S), .ADDR_WIDTH(32), .JUMP_STAGE(JS), .MEM_STAGE(MS), .MAX_WAIT(MW),
        .RESET_PC(32'h0), .TIMEOUT_VEC(TO_VEC)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.stallreq_i    = '0;
        bus.jump_enable_i = 1'b0;
        bus.jump_addr_i   = '0;
        bus.trap_i        = 1'b0;
        bus.trap_vec_i    = '0;
        bus.mem_req_i     = 1'b0;
        bus.mem_ack_i     = 1'b0;
    endtask

    // Behavioural model: which phase of a redirect/wait sequence we are in, and the pending target.
    int          m_wait;
    bit          m_drain, m_redir, m_to, m_valid;
    logic [31:0] m_tgt, m_pc;
    logic [5:0]  es, ef;
    logic [1:0]  est;
    bit          n_redir, n_drain;
    int          n_wait, k;
    bit          jump_ok;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                m_wait = 0; m_drain = 0; m_redir = 0; m_to = 0; m_valid = 0;
                m_tgt = '0; m_pc = '0;
                check("m_rst_stall", bus.stall_o, 0);
                check("m_rst_flush", bus.flush_o, 0);
                check("m_rst_state", bus.state_o, 0);
                check("m_rst_pc",    bus.new_pc_o, 0);
                check("m_rst_valid", bus.new_pc_valid_o, 0);
                check("m_rst_to",    bus.timeout_o, 0);
            end else begin
                jump_ok = bus.jump_enable_i && ((bus.stallreq_i >> JS) == 0);
                es = '0;
                ef = '0;
                if (m_redir) ef = 6'b000010;
                else if (m_drain) ef = 6'b111110;
                else if (m_wait > 0) begin
                    if (!bus.mem_ack_i) begin
                        if (m_wait < MW) begin
                            es = 6'((1 << (MS + 1)) - 1);
                            ef = (MS + 1 < S) ? 6'(1 << (MS + 1)) : 6'd0;
                        end else ef = 6'b111110;
                    end
                end else if (bus.trap_i) ef = 6'b111110;
                else if (bus.mem_req_i && !bus.mem_ack_i) begin
                    es = 6'((1 << (MS + 1)) - 1);
                    ef = (MS + 1 < S) ? 6'(1 << (MS + 1)) : 6'd0;
                end else if (jump_ok) ef = 6'((1 << (JS + 1)) - 2);
                else begin
                    k = -1;
                    for (int i = 0; i < S; i++) if (bus.stallreq_i[i]) k = i;
                    if (k >= 0) begin
                        es = 6'((1 << (k + 1)) - 1);
                        if (k + 1 < S) ef = 6'(1 << (k + 1));
                    end
                end
                est = m_redir ? 2'd3 : m_drain ? 2'd2 : (m_wait > 0) ? 2'd1 : 2'd0;
                check("m_stall", bus.stall_o, es);
                check("m_flush", bus.flush_o, ef);
                check("m_state", bus.state_o, est);
                check("m_pc",    bus.new_pc_o, m_pc);
                check("m_valid", bus.new_pc_valid_o, m_valid);
                check("m_to",    bus.timeout_o, m_to);

                n_redir = 0; n_drain = 0; n_wait = 0;
                if (m_redir) begin
                end else if (m_drain) n_redir = 1;
                else if (m_wait > 0) begin
                    if (!bus.mem_ack_i) begin
                        if (m_wait < MW) n_wait = m_wait + 1;
                        else begin
                            m_to = 1; m_tgt = TO_VEC; n_drain = 1;
                        end
                    end
                end else if (bus.trap_i) begin
                    m_tgt = bus.trap_vec_i; n_drain = 1;
                end else if (bus.mem_req_i && !bus.mem_ack_i) n_wait = 1;
                else if (jump_ok) begin
                    m_tgt = bus.jump_addr_i; n_redir = 1;
                end
                m_redir = n_redir;
                m_drain = n_drain;
                m_wait  = n_wait;
                m_valid = n_redir;
                if (n_redir) m_pc = m_tgt;
            end
        end
    end

    initial begin
        idle();
        rst_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", bus.state_o, 0);
        check("rst_pc",    bus.new_pc_o, 0);
        check("rst_valid", bus.new_pc_valid_o, 0);
        check("rst_to",    bus.timeout_o, 0);
        @(posedge clk); #1 rst_i = 1'b1;

        // Stall priority
        bus.stallreq_i = 6'b000100;
        @(negedge clk);
        check("stall_k2", bus.stall_o, 6'b000111);
        check("flush_k2", bus.flush_o, 6'b001000);
        @(posedge clk); #1 bus.stallreq_i = 6'b001010;
        @(negedge clk);
        check("stall_k3", bus.stall_o, 6'b001111);
        check("flush_k3", bus.flush_o, 6'b010000);

        // Jump to 0x100
        @(posedge clk); #1 bus.stallreq_i = '0; bus.jump_enable_i = 1'b1; bus.jump_addr_i = 32'h100;
        @(negedge clk);
        check("jmp_flush", bus.flush_o, 6'b001110);
        check("jmp_stall", bus.stall_o, 6'b000000);
        @(posedge clk); #1 bus.jump_enable_i = 1'b0;
        @(negedge clk);
        check("jmp_valid", bus.new_pc_valid_o, 1);
        check("jmp_pc",    bus.new_pc_o, 32'h100);
        check("jmp_rflush", bus.flush_o, 6'b000010);
        check("jmp_state", bus.state_o, 3);
        @(posedge clk); #1;
        @(negedge clk);
        check("jmp_back_state", bus.state_o, 0);
        check("jmp_back_valid", bus.new_pc_valid_o, 0);

        // Jump blocked by MEM stall
        @(posedge clk); #1 bus.jump_enable_i = 1'b1; bus.stallreq_i = 6'b010000;
        @(negedge clk);
        check("blk_stall", bus.stall_o, 6'b011111);
        check("blk_flush", bus.flush_o, 6'b100000);
        check("blk_state", bus.state_o, 0);
        @(posedge clk); #1 bus.jump_enable_i = 1'b0; bus.stallreq_i = '0;
        @(negedge clk);
        check("blk_valid", bus.new_pc_valid_o, 0);
        check("blk_state2", bus.state_o, 0);

        // Memory wait acked on the 4th cycle
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 bus.mem_req_i = 1'b1; bus.mem_ack_i = (i == 3);
            @(negedge clk);
            check("mw_stall", bus.stall_o, (i < 3) ? 6'b011111 : 6'b000000);
        end
        check("mw_ack_flush", bus.flush_o, 6'b000000);
        @(posedge clk); #1 bus.mem_req_i = 1'b0; bus.mem_ack_i = 1'b0;
        @(negedge clk);
        check("mw_state", bus.state_o, 0);

        // Timeout with MAX_WAIT=4
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 bus.mem_req_i = 1'b1;
            @(negedge clk);
            check("to_stall", bus.stall_o, 6'b011111);
            check("to_flag_lo", bus.timeout_o, 0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("to_flush1", bus.flush_o, 6'b111110);
        check("to_stall0", bus.stall_o, 6'b000000);
        @(posedge clk); #1 bus.mem_req_i = 1'b0;
        @(negedge clk);
        check("to_flag", bus.timeout_o, 1);
        check("to_flush2", bus.flush_o, 6'b111110);
        check("to_drain", bus.state_o, 2);
        @(posedge clk); #1;
        @(negedge clk);
        check("to_valid", bus.new_pc_valid_o, 1);
        check("to_pc", bus.new_pc_o, 32'h40);
        @(posedge clk); #1;
        @(negedge clk);
        check("to_back", bus.state_o, 0);
        check("to_sticky", bus.timeout_o, 1);

        // Trap to 0x80
        @(posedge clk); #1 bus.trap_i = 1'b1; bus.trap_vec_i = 32'h80;
        @(negedge clk);
        check("trap_flush1", bus.flush_o, 6'b111110);
        check("trap_stall", bus.stall_o, 6'b000000);
        @(posedge clk); #1 bus.trap_i = 1'b0;
        @(negedge clk);
        check("trap_flush2", bus.flush_o, 6'b111110);
        check("trap_nvalid", bus.new_pc_valid_o, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("trap_valid", bus.new_pc_valid_o, 1);
        check("trap_pc", bus.new_pc_o, 32'h80);

        // Asynchronous reset in the middle of a memory wait
        @(posedge clk); #1 bus.mem_req_i = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("ar_wait_state", bus.state_o, 1);
        #2 rst_i = 1'b0;
        #1;
        check("ar_stall", bus.stall_o, 0);
        check("ar_flush", bus.flush_o, 0);
        check("ar_state", bus.state_o, 0);
        check("ar_pc", bus.new_pc_o, 0);
        check("ar_to", bus.timeout_o, 0);
        @(negedge clk);
        @(posedge clk); #1 rst_i = 1'b1; bus.mem_req_i = 1'b0;

        // Randomized traffic with rare resets
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst_i = ($urandom_range(0, 299) != 0);
            for (int b = 0; b < S; b++) bus.stallreq_i[b] = ($urandom_range(0, 5) == 0);
            bus.jump_enable_i = ($urandom_range(0, 3) == 0);
            bus.jump_addr_i   = $urandom;
            bus.trap_i        = ($urandom_range(0, 15) == 0);
            bus.trap_vec_i    = $urandom;
            bus.mem_req_i     = ($urandom_range(0, 3) == 0);
            bus.mem_ack_i     = ($urandom_range(0, 3) == 0);
        end
        @(posedge clk); #1 idle(); rst_i = 1'b1;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl_n.md
Name: pipe_ctrl_n

Overview:
- Parametrised, stateful successor to the combinational pipeline controller.
- Produces per-stage stall and flush vectors for an N-stage in-order core.
- Sequences branch redirects, multi-cycle memory waits with timeout, and trap entry through a registered FSM.
- Sits between the stage stall/jump/trap sources and pc_reg plus every pipeline register.

Parameters:
STAGES, 6, stage count; index 0=PC, 1=IF, 2=ID, 3=EXE, 4=MEM, 5=WB
ADDR_WIDTH, 32, PC width
JUMP_STAGE, 3, stage that resolves jumps
MEM_STAGE, 4, stage that issues data-memory requests
MAX_WAIT, 15, maximum MEM_WAIT cycles before timeout (>=1)
RESET_PC, 0, new_pc_o value after reset
TIMEOUT_VEC, 32'h0000_0040, redirect target on memory timeout
Constraint: 1 <= JUMP_STAGE < MEM_STAGE <= STAGES-1.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset; one clock; reset is asynchronous and active-low
stallreq_i  in  STAGES  per-stage stall request
jump_enable_i  in  1  jump resolved at JUMP_STAGE
jump_addr_i  in  ADDR_WIDTH  jump target
trap_i  in  1  synchronous trap request
trap_vec_i  in  ADDR_WIDTH  trap target
mem_req_i  in  1  MEM_STAGE data access in progress
mem_ack_i  in  1  data access completes this cycle
stall_o  out  STAGES  stage i holds its register
flush_o  out  STAGES  register at entry of stage i loads bubble at next edge; bit 0 always 0
new_pc_o  out  ADDR_WIDTH  redirect PC (registered)
new_pc_valid_o  out  1  pc_reg loads new_pc_o (registered)
timeout_o  out  1  sticky memory-timeout flag (registered)
state_o  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 DRAIN, 3 REDIRECT

Behaviour:
- Reset (rst_i=0, any time, including mid-wait or mid-redirect):
  - state=RUN, wait_cnt=0, new_pc_o=RESET_PC, new_pc_valid_o=0, timeout_o=0.
  - stall_o and flush_o are forced to 0 while rst_i is low.
- stall_o and flush_o are combinational from state and inputs. All other outputs are registered.
- RUN, evaluated in priority order:
  1. trap_i=1: flush_o[STAGES-1:1]=all ones, stall_o=0; latch trap_vec_i; next state DRAIN.
  2. mem_req_i=1 and mem_ack_i=0: stall_o[MEM_STAGE:0]=all ones, flush_o[MEM_STAGE+1]=1 (bubble into the next stage, if it exists); wait_cnt<=1; next state MEM_WAIT.
  3. jump_enable_i=1 and no stallreq_i[j] for j>=JUMP_STAGE: stall_o=0, flush_o[JUMP_STAGE:1]=all ones; latch jump_addr_i; next state REDIRECT.
  4. Otherwise, with k = highest index where stallreq_i[k]=1:
     - stall_o[k:0]=1, flush_o[k+1]=1 if k+1<STAGES.
     - No request: all zero.
  - A jump blocked by a stall at or beyond JUMP_STAGE is dropped; EXE re-presents it.
- MEM_WAIT:
  - mem_ack_i=1: stall_o=0; wait_cnt<=0; next state RUN. The pipeline advances in the ack cycle.
  - mem_ack_i=0 and wait_cnt<MAX_WAIT: stall_o[MEM_STAGE:0]=1, bubble as above; wait_cnt++.
  - mem_ack_i=0 and wait_cnt==MAX_WAIT: full flush; timeout_o<=1; latch TIMEOUT_VEC; next state DRAIN.
  - trap_i, jump_enable_i and stallreq_i are ignored in this state.
- DRAIN (exactly 1 cycle): full flush, stall_o=0, all inputs ignored; next state REDIRECT.
- REDIRECT (exactly 1 cycle):
  - new_pc_valid_o=1, new_pc_o=latched target, flush_o[1]=1 (kills the wrong-path fetch), stall_o=0.
  - Inputs are ignored; a jump or trap presented here is lost, since the flush kills its source.
  - Next state RUN; new_pc_valid_o returns to 0.
- Redirect penalty: the jump/trap cycle plus 1 cycle for a jump; 2 cycles for a trap.
- timeout_o stays set until reset.
- new_pc_o holds its last value outside REDIRECT.
- wait_cnt width is clog2(MAX_WAIT+1).

Test Plan:
- Reset: assert rst_i=0 during MEM_WAIT -> stall_o=0, flush_o=0, state_o=0, new_pc_o=0, timeout_o=0, immediately and asynchronously.
- Stall priority: stallreq_i=6'b000100 -> stall_o=6'b000111, flush_o=6'b001000. Then stallreq_i=6'b001010 -> stall_o=6'b001111, flush_o=6'b010000.
- Jump at 0x100, no stall:
  - Acceptance cycle: flush_o=6'b001110.
  - Next cycle: new_pc_valid_o=1, new_pc_o=0x100, flush_o=6'b000010, state_o=3.
  - Following cycle: state_o=0, new_pc_valid_o=0.
- Blocked jump: jump_enable_i=1 with stallreq_i[4]=1 -> stall_o=6'b011111, flush_o=6'b100000, no new_pc_valid_o pulse, state_o stays 0.
- Memory wait: mem_req_i=1, mem_ack_i=1 on the 4th cycle -> stall_o=6'b011111 for 3 cycles; stall_o=0 in the ack cycle; state_o back to 0.
- Timeout and trap:
  - MAX_WAIT=4, no ack -> timeout_o=1 after the 4th wait cycle, then flush_o=6'b111110 for 2 cycles, then new_pc_valid_o=1 with new_pc_o=0x40.
  - trap_i with trap_vec_i=0x80 -> same 2-cycle flush, then new_pc_o=0x80.
